// File: rtl/debug_uart_dump_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : debug_uart_dump_if
//  Purpose  : Bundles the dump request/status handshake, the debug selector
//             bus and the UART line of debug_uart_dump.
//  Signals  : start        - single-cycle dump request
//             debug_addr   - [6:0] selector index (driven by the dumper)
//             debug_data   - [31:0] selector data for debug_addr
//             debug_label  - [55:0] 7 ASCII label chars, MSB byte first
//             tx           - UART 8N1 serial line, idle high
//             busy         - dump in progress
//             done         - one-cycle completion pulse
//  Modports : master - the dumper; slave - the surrounding system
//  Revision : 1.0 - initial release
// ============================================================================
interface debug_uart_dump_if;
  logic        start;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic [55:0] debug_label;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    input  start, debug_data, debug_label,
    output debug_addr, tx, busy, done
  );

  modport slave (
    output start, debug_data, debug_label,
    input  debug_addr, tx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/debug_uart_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : debug_uart_dump
//  Purpose  : On a start request, walks debug_addr over 0..NUM_ENTRIES-1,
//             latches each selector value and prints it over a UART 8N1 line
//             as 8 uppercase hex digits followed by CR LF.
//  Ports    : clk      - system clock, rising edge
//             reset_n  - asynchronous active-low reset
//             bus      - debug_uart_dump_if.master (start, debug_addr,
//                        debug_data, debug_label, tx, busy, done)
//  Params   : BAUD_DIV    - clk cycles per UART bit
//             NUM_ENTRIES - entries dumped per run (1..128)
//  Macro    : DEBUG_UART_LABEL_EN - when defined, each line is prefixed with
//             the 7-char debug_label and a space (18 chars per line).
//  Revision : 1.0 - initial release
// ============================================================================
module debug_uart_dump #(
  parameter int BAUD_DIV    = 1736,
  parameter int NUM_ENTRIES = 32
) (
  input wire                clk,
  input wire                reset_n,
  debug_uart_dump_if.master bus
);

  localparam int                BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [6:0]        ADDR_LAST = 7'(NUM_ENTRIES - 1);
  localparam logic [3:0]        BIT_STOP  = 4'd9;
`ifdef DEBUG_UART_LABEL_EN
  localparam logic [4:0]        CHAR_LAST = 5'd17;
`else
  localparam logic [4:0]        CHAR_LAST = 5'd9;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_SEND   = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t            state_q;
  logic [6:0]        addr_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;    // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [4:0]        char_q;   // character position within the line
  logic [31:0]       data_q;
`ifdef DEBUG_UART_LABEL_EN
  logic [55:0]       label_q;
`endif

  // Character currently being shifted out, selected from the line buffer.
  logic [3:0] hex_nib;
  logic [7:0] hex_char;
  logic [7:0] cur_char;

  always_comb begin
    // Hex digit k (0 = most significant) lives at data_q[(7-k)*4 +: 4]; the
    // hex field starts on a multiple of 8 in both line formats, so the low
    // three bits of the character index give k directly.
    hex_nib  = data_q[{~char_q[2:0], 2'b00} +: 4];
    hex_char = (hex_nib < 4'd10) ? (8'h30 + {4'h0, hex_nib})
                                 : (8'h37 + {4'h0, hex_nib});
    cur_char = 8'h0A;
`ifdef DEBUG_UART_LABEL_EN
    if (char_q < 5'd7) begin
      cur_char = label_q[{3'd6 - char_q[2:0], 3'b000} +: 8];
    end else if (char_q == 5'd7) begin
      cur_char = 8'h20;
    end else if (char_q < 5'd16) begin
      cur_char = hex_char;
    end else if (char_q == 5'd16) begin
      cur_char = 8'h0D;
    end
`else
    if (char_q < 5'd8) begin
      cur_char = hex_char;
    end else if (char_q == 5'd8) begin
      cur_char = 8'h0D;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 7'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      char_q  <= 5'd0;
      data_q  <= 32'd0;
`ifdef DEBUG_UART_LABEL_EN
      label_q <= 56'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_FETCH;
            addr_q  <= 7'd0;
            busy_q  <= 1'b1;
          end
        end

        // One cycle for the external selector to settle on debug_addr.
        S_FETCH: state_q <= S_LATCH;

        S_LATCH: begin
          data_q  <= bus.debug_data;
`ifdef DEBUG_UART_LABEL_EN
          label_q <= bus.debug_label;
`endif
          char_q  <= 5'd0;
          bit_q   <= 4'd0;
          baud_q  <= '0;
          tx_q    <= 1'b0;           // start bit of the first character
          state_q <= S_SEND;
        end

        S_SEND: begin
          if (baud_q != BAUD_LAST) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            if (bit_q != BIT_STOP) begin
              // tx is loaded with the level of the bit about to begin.
              bit_q <= bit_q + 4'd1;
              tx_q  <= (bit_q == 4'd8) ? 1'b1 : cur_char[bit_q[2:0]];
            end else begin
              bit_q <= 4'd0;
              if (char_q == CHAR_LAST) begin
                char_q  <= 5'd0;
                tx_q    <= 1'b1;
                state_q <= S_NEXT;
              end else begin
                // Next character's start bit follows with no idle gap.
                char_q <= char_q + 5'd1;
                tx_q   <= 1'b0;
              end
            end
          end
        end

        S_NEXT: begin
          if (addr_q == ADDR_LAST) begin
            addr_q  <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            addr_q  <= addr_q + 7'd1;
            state_q <= S_FETCH;
          end
        end

        // done is high during this cycle; start is not sampled here.
        S_FINISH: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.debug_addr = addr_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: doc/debug_uart_dump.md
DEBUG_UART_DUMP -- requirements
Module: debug_uart_dump

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 1736, meaning clk cycles per UART bit (200 MHz / 115200).
REQ-002 SHALL have parameter NUM_ENTRIES, default 32, meaning debug entries dumped per run (range 1..128).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a dump.
REQ-006 SHALL have port debug_addr  output  7  index driven to the debug signal selector.
REQ-007 SHALL have port debug_data  input  32  selector data for debug_addr (combinational path from debug_addr).
REQ-008 SHALL have port debug_label  input  56  7 ASCII chars naming the entry, MSB byte first.
REQ-009 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a dump is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the last entry's final stop bit completes.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, LATCH, SEND, NEXT, FINISH.
REQ-013 IDLE: start=1 -> FETCH, debug_addr=0, busy=1 on next cycle; start=0 -> stay.
REQ-014 FETCH: hold debug_addr one cycle for selector settling -> LATCH.
REQ-015 LATCH: register debug_data and debug_label into a line buffer, character index=0 -> SEND.
REQ-016 Line format: 8 uppercase hex digits of debug_data, MSB nibble first ('0'-'9'=0x30-0x39, 'A'-'F'=0x41-0x46), then CR (0x0D), LF (0x0A): 10 chars.
REQ-017 SEND: each char is start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly BAUD_DIV cycles; characters back-to-back with no idle gap.
REQ-018 After the last char of a line -> NEXT; NEXT: if debug_addr==NUM_ENTRIES-1 -> FINISH, else debug_addr+1 -> FETCH.
REQ-019 FINISH: done=1 for exactly one cycle, busy=0, debug_addr=0 -> IDLE.
REQ-020 start while busy=1 SHALL be ignored (not queued).
REQ-021 start in the same cycle as done SHALL be ignored; start the cycle after done SHALL be accepted.
REQ-022 debug_data/debug_label changes after LATCH SHALL NOT affect the line in transmission.
REQ-023 Baud counter SHALL be wide enough for BAUD_DIV-1 and SHALL wrap to 0 at each bit boundary.
REQ-024 tx SHALL be registered (glitch-free); tx=1 in every state except SEND.

Reset
REQ-025 reset_n=0 SHALL immediately force: state IDLE, tx=1, busy=0, done=0, debug_addr=0, all counters 0.
REQ-026 Reset asserted mid-character SHALL abort the dump; no partial resume after release.
REQ-027 First start SHALL be accepted on the first clk edge with reset_n=1.

Configuration
REQ-028 Macro DEBUG_UART_LABEL_EN defined: each line SHALL be the 7 debug_label chars, space (0x20), 8 hex digits, CR, LF (18 chars).
REQ-029 Macro DEBUG_UART_LABEL_EN undefined: line per REQ-016 (10 chars); debug_label SHALL be unused and its buffer not synthesized.

Verification
REQ-030 BAUD_DIV=4, NUM_ENTRIES=1, debug_data=0x000000AF, start pulse -> tx bytes "000000AF\r\n" (0x30x6,0x41,0x46,0x0D,0x0A), 400 SEND cycles, one done pulse.
REQ-031 BAUD_DIV=4, NUM_ENTRIES=3, debug_data=addr*0x11111111 -> lines "00000000","11111111","22222222", debug_addr sequence 0,1,2 then 0, busy high throughout.
REQ-032 start pulses every 50 cycles during REQ-031 run -> no extra lines, exactly one done.
REQ-033 reset_n low at cycle 130 of a dump -> tx=1, busy=0 same cycle asynchronously; new start after release yields full correct output.
REQ-034 With DEBUG_UART_LABEL_EN, debug_label="x1     " (0x78,0x31,0x20x5), debug_data=0xDEADBEEF -> "x1      DEADBEEF\r\n", 720 SEND cycles at BAUD_DIV=4.
REQ-035 Change debug_data every cycle after LATCH -> transmitted line equals the value latched in LATCH.
